// File: rtl/decoder_rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with a registered winner index decoded to a one-hot grant.
// Optional ARB_LOCK_EN adds a lock input that suppresses preemption of the current holder.
module decoder_rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
`ifdef ARB_LOCK_EN
  input  logic       lock,
`endif
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid
);

  localparam int unsigned HoldW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD);
  localparam logic [HoldW-1:0] HoldOne = HoldW'(1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       id_q, id_d;
  logic [HoldW-1:0] hold_q, hold_d;

  logic [7:0] holder_oh;
  logic [7:0] others;
  logic [2:0] next_ptr;
  logic       lock_act;

`ifdef ARB_LOCK_EN
  assign lock_act = lock;
`else
  assign lock_act = 1'b0;
`endif

  // First set bit of cand, scanning start, start+1, ... modulo 8.
  function automatic logic [2:0] rr_pick(input logic [7:0] cand, input logic [2:0] start);
    logic [2:0] idx;
    logic [2:0] pick;
    logic       found;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = start + 3'(i);
      if (!found && cand[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    hold_d    = hold_q;
    holder_oh = 8'b1 << id_q;
    others    = req & ~holder_oh;
    next_ptr  = id_q + 3'd1;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d = StGrant;
          id_d    = rr_pick(req, ptr_q);
          hold_d  = HoldOne;
        end
      end
      StGrant: begin
        if (!req[id_q]) begin
          ptr_d = next_ptr;
          if (|others) begin
            id_d   = rr_pick(others, next_ptr);
            hold_d = HoldOne;
          end else begin
            state_d = StIdle;
          end
        end else if (MAX_HOLD != 0 && !lock_act && hold_q == HoldMax && |others) begin
          ptr_d  = next_ptr;
          id_d   = rr_pick(others, next_ptr);
          hold_d = HoldOne;
        end else if (!lock_act && hold_q < HoldMax) begin
          hold_d = hold_q + HoldOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= 3'd0;
      id_q    <= 3'd0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt_valid = (state_q == StGrant);
  assign gnt_id    = id_q;
  assign gnt       = gnt_valid ? (8'b1 << id_q) : 8'h00;

endmodule

// File: tb/tb_decoder_rr_arbiter8.sv
// Directed self-checking bench for decoder_rr_arbiter8 (MAX_HOLD = 4).
// Build with +define+ARB_LOCK_EN to also exercise the lock input.
module tb_decoder_rr_arbiter8;

  logic       clk;
  logic       rst;
  logic       lock;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;

  int checks;
  int errors;

  decoder_rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef ARB_LOCK_EN
    .lock     (lock),
`endif
    .req      (req),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .gnt_valid(gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs reflect that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req  = 8'h00;
    lock = 1'b0;
    tick();
    tick();
    checks++;
    if ({gnt, gnt_id, gnt_valid} !== {8'h00, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got gnt=%h id=%0d v=%b exp gnt=00 id=0 v=0", gnt, gnt_id,
               gnt_valid);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({gnt, gnt_id, gnt_valid} !== {8'h00, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL idle_after_reset got gnt=%h id=%0d v=%b exp gnt=00 id=0 v=0", gnt, gnt_id,
               gnt_valid);
    end
  endtask

  task automatic test_single();
    req = 8'b0000_0100;
    tick();
    checks++;
    if ({gnt, gnt_id, gnt_valid} !== {8'h04, 3'd2, 1'b1}) begin
      errors++;
      $display("FAIL single_grant got gnt=%h id=%0d v=%b exp gnt=04 id=2 v=1", gnt, gnt_id,
               gnt_valid);
    end
    req = 8'h00;
    tick();
    checks++;
    if ({gnt, gnt_id, gnt_valid} !== {8'h00, 3'd2, 1'b0}) begin
      errors++;
      $display("FAIL single_release got gnt=%h id=%0d v=%b exp gnt=00 id=2 v=0", gnt, gnt_id,
               gnt_valid);
    end
    tick();
    checks++;
    if ({gnt, gnt_id, gnt_valid} !== {8'h00, 3'd2, 1'b0}) begin
      errors++;
      $display("FAIL idle_hold got gnt=%h id=%0d v=%b exp gnt=00 id=2 v=0", gnt, gnt_id,
               gnt_valid);
    end
  endtask

  // Pointer is 3 after the release of index 2, so req=FF picks index 3.
  task automatic test_reset_mid();
    req = 8'hFF;
    tick();
    checks++;
    if ({gnt, gnt_id, gnt_valid} !== {8'h08, 3'd3, 1'b1}) begin
      errors++;
      $display("FAIL ptr_scan got gnt=%h id=%0d v=%b exp gnt=08 id=3 v=1", gnt, gnt_id,
               gnt_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({gnt, gnt_id, gnt_valid} !== {8'h00, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got gnt=%h id=%0d v=%b exp gnt=00 id=0 v=0", gnt, gnt_id,
               gnt_valid);
    end
    tick();
    tick();
    checks++;
    if ({gnt, gnt_id, gnt_valid} !== {8'h00, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_held got gnt=%h id=%0d v=%b exp gnt=00 id=0 v=0", gnt, gnt_id,
               gnt_valid);
    end
    rst = 1'b0;
  endtask

  // Fresh pointer 0: 01 x4, 80 x4, 01 x4, then 80 again; req drop of bit 7 wraps to 0.
  task automatic test_rotation_wrap();
    logic [7:0] exp_gnt;
    logic [2:0] exp_id;
    req = 8'b1000_0001;
    for (int i = 0; i < 13; i++) begin
      tick();
      exp_gnt = (((i / 4) % 2) == 0) ? 8'h01 : 8'h80;
      exp_id  = (((i / 4) % 2) == 0) ? 3'd0 : 3'd7;
      checks++;
      if ({gnt, gnt_id, gnt_valid} !== {exp_gnt, exp_id, 1'b1}) begin
        errors++;
        $display("FAIL rotation cycle %0d got gnt=%h id=%0d v=%b exp gnt=%h id=%0d v=1", i, gnt,
                 gnt_id, gnt_valid, exp_gnt, exp_id);
      end
    end
    req = 8'b0000_0011;
    tick();
    checks++;
    if ({gnt, gnt_id, gnt_valid} !== {8'h01, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL wrap got gnt=%h id=%0d v=%b exp gnt=01 id=0 v=1", gnt, gnt_id, gnt_valid);
    end
  endtask

  // Holder 0 releases into index 4; lone holder keeps it, then preemption scans 5,6,7,0.
  task automatic test_single_holder();
    int bad;
    bad = 0;
    req = 8'h10;
    for (int i = 0; i < 20; i++) begin
      tick();
      if ({gnt, gnt_id, gnt_valid} !== {8'h10, 3'd4, 1'b1}) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL lone_holder got %0d bad cycles exp 0 (last gnt=%h id=%0d)", bad, gnt,
               gnt_id);
    end
    req = 8'h11;
    tick();
    checks++;
    if ({gnt, gnt_id, gnt_valid} !== {8'h01, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL saturated_preempt got gnt=%h id=%0d v=%b exp gnt=01 id=0 v=1", gnt, gnt_id,
               gnt_valid);
    end
  endtask

  task automatic test_back_to_back();
    req = 8'b0000_0110;
    tick();
    checks++;
    if ({gnt, gnt_id, gnt_valid} !== {8'h02, 3'd1, 1'b1}) begin
      errors++;
      $display("FAIL b2b_first got gnt=%h id=%0d v=%b exp gnt=02 id=1 v=1", gnt, gnt_id,
               gnt_valid);
    end
    req = 8'b0000_0100;
    tick();
    checks++;
    if ({gnt, gnt_id, gnt_valid} !== {8'h04, 3'd2, 1'b1}) begin
      errors++;
      $display("FAIL b2b_second got gnt=%h id=%0d v=%b exp gnt=04 id=2 v=1", gnt, gnt_id,
               gnt_valid);
    end
    req = 8'h00;
    tick();
    checks++;
    if ({gnt, gnt_id, gnt_valid} !== {8'h00, 3'd2, 1'b0}) begin
      errors++;
      $display("FAIL b2b_idle got gnt=%h id=%0d v=%b exp gnt=00 id=2 v=0", gnt, gnt_id,
               gnt_valid);
    end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    int bad;
    bad = 0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    req = 8'b1000_0001;
    lock = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    lock = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if ({gnt, gnt_id, gnt_valid} !== {8'h01, 3'd0, 1'b1}) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL lock_hold got %0d bad cycles exp 0 (last gnt=%h)", bad, gnt);
    end
    lock = 1'b0;
    tick();
    checks++;
    if ({gnt, gnt_id, gnt_valid} !== {8'h80, 3'd7, 1'b1}) begin
      errors++;
      $display("FAIL lock_release got gnt=%h id=%0d v=%b exp gnt=80 id=7 v=1", gnt, gnt_id,
               gnt_valid);
    end
    req = 8'h00;
    tick();
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_reset_mid();
    test_rotation_wrap();
    test_single_holder();
    test_back_to_back();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
